// File: rtl/pdm_delay_sum_beamformer_if.sv
// Bus interface for pdm_delay_sum_beamformer: PDM input strobe, delay configuration
// channel and the frame-result output handshake. The driver of pdm/cfg inputs and
// consumer of results uses the master modport; the beamformer core uses slave.
interface pdm_delay_sum_beamformer_if #(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned DECIM     = 32
);
    localparam int unsigned CW  = $clog2(NUM_CH);
    localparam int unsigned DLW = $clog2(MAX_DELAY);
    localparam int unsigned OW  = $clog2(NUM_CH * DECIM + 1);

    logic              pdm_valid;
    logic [NUM_CH-1:0] pdm_in;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CW-1:0]     cfg_ch;
    logic [DLW-1:0]    cfg_delay;
    logic              cfg_commit;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              overrun;

    modport master (
        output pdm_valid, pdm_in, cfg_valid, cfg_ch, cfg_delay, cfg_commit, out_ready,
        input  cfg_ready, out_valid, out_data, overrun
    );

    modport slave (
        input  pdm_valid, pdm_in, cfg_valid, cfg_ch, cfg_delay, cfg_commit, out_ready,
        output cfg_ready, out_valid, out_data, overrun
    );
endinterface

// File: rtl/pdm_delay_sum_beamformer.sv
// Delay-and-sum beamformer core. Each channel's PDM bit is delayed by a programmable
// number of strobes, the aligned bits are popcounted and accumulated over DECIM
// strobes into one unsigned frame word. Delay updates are staged in a shadow table
// and copied to the active table only at a frame boundary.
// Optional feature: define BF_CHMASK_EN to add a live per-channel ch_mask input.
module pdm_delay_sum_beamformer #(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned MAX_DELAY = 16,
    parameter int unsigned DECIM     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef BF_CHMASK_EN
    input  logic [NUM_CH-1:0]            ch_mask,
`endif
    pdm_delay_sum_beamformer_if.slave    bus
);
    localparam int unsigned DLW  = $clog2(MAX_DELAY);
    localparam int unsigned OW   = $clog2(NUM_CH * DECIM + 1);
    localparam int unsigned SW   = $clog2(NUM_CH + 1);
    localparam int unsigned CNTW = $clog2(DECIM);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    state_e                 state_q, state_d;
    logic                   cfg_ready;

    logic [MAX_DELAY-2:0]   sr_q     [NUM_CH];
    logic [MAX_DELAY-1:0]   line     [NUM_CH];
    logic [DLW-1:0]         shadow_q [NUM_CH];
    logic [DLW-1:0]         active_q [NUM_CH];
    logic [NUM_CH-1:0]      tap;
    logic [SW-1:0]          sum;
    logic [OW-1:0]          acc_q;
    logic [OW-1:0]          frame_sum;
    logic [CNTW-1:0]        cnt_q;
    logic                   boundary;
    logic                   cfg_write;

    logic                   out_valid_q;
    logic [OW-1:0]          out_data_q;
    logic                   overrun_q;

    // line[ch][0] is the live bit, line[ch][d] the bit from d strobes ago.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign line[g] = {sr_q[g], bus.pdm_in[g]};
`ifdef BF_CHMASK_EN
        assign tap[g]  = line[g][active_q[g]] & ch_mask[g];
`else
        assign tap[g]  = line[g][active_q[g]];
`endif
    end

    // Popcount of the delayed taps for the current strobe.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SW'(tap[i]);
        end
    end

    assign frame_sum = acc_q + OW'(sum);
    assign boundary  = bus.pdm_valid && (cnt_q == CNTW'(DECIM - 1));
    assign cfg_write = cfg_ready && bus.cfg_valid && (int'(bus.cfg_ch) < int'(NUM_CH));

    // Per-channel delay lines shift only on a strobe; masked channels still shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sr_q[i] <= '0;
            end
        end else if (bus.pdm_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sr_q[i] <= line[i][MAX_DELAY-2:0];
            end
        end
    end

    // Frame accumulator and strobe counter; cleared on the boundary strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (boundary) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (bus.pdm_valid) begin
            acc_q <= frame_sum;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output register: a boundary always loads the new frame, flagging a lost one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else if (boundary) begin
            out_valid_q <= 1'b1;
            out_data_q  <= frame_sum;
            if (out_valid_q && !bus.out_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Shadow delay table; writes only while the config port is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (cfg_write) begin
            shadow_q[bus.cfg_ch] <= bus.cfg_delay;
        end
    end

    // Active delay table; the boundary strobe itself still sees the old delays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= '0;
            end
        end else if (state_q == StPending && boundary) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Config FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Config FSM next state: a commit seen on a boundary waits for the following one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.cfg_commit) state_d = StPending;
            StPending: if (boundary)       state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Config FSM outputs.
    always_comb begin
        cfg_ready = (state_q == StIdle);
    end

    assign bus.cfg_ready = cfg_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.overrun   = overrun_q;

endmodule
